// File: rtl/tmr_cnt_ctrl.sv
// Count-path sequencer for the 8-bit timer: load/run/clock-switch control, TCNT, sticky flags.
// Optional: define TMR_AUTO_RELOAD_EN to reload tcnt from tdr on overflow/underflow instead of wrapping.
module tmr_cnt_ctrl #(
    parameter int unsigned BLANK_CYC = 3,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             pclk,
    input  logic             preset_n,
    input  logic             tmr_en,
    input  logic             load_req,
    input  logic [CNT_W-1:0] tdr,
    input  logic             count_dn,
    input  logic [1:0]       cks_in,
    input  logic             tmr_edge,
    input  logic             ovf_clr,
    input  logic             udf_clr,
    output logic [1:0]       cks_out,
    output logic [CNT_W-1:0] tcnt,
    output logic             ovf_flag,
    output logic             udf_flag,
    output logic             load_ack,
    output logic             busy
);

    localparam int unsigned BLK_W = (BLANK_CYC < 1) ? 1 : $clog2(BLANK_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_RUN    = 2'd2,
        S_SWITCH = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [BLK_W-1:0]   blank, blank_n;
    logic [CNT_W-1:0]   tcnt_n;
    logic [1:0]         cks_n;
    logic               ovf_n, udf_n, load_ack_n, busy_n;
    logic               ovf_set, udf_set, cnt_en, cks_chg;
    logic [CNT_W-1:0]   wrap_up, wrap_dn;

`ifdef TMR_AUTO_RELOAD_EN
    assign wrap_up = tdr;
    assign wrap_dn = tdr;
`else
    assign wrap_up = '0;
    assign wrap_dn = '1;
`endif

    assign cks_chg = (cks_in != cks_out);

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state    <= S_IDLE;
            tcnt     <= '0;
            cks_out  <= 2'b00;
            ovf_flag <= 1'b0;
            udf_flag <= 1'b0;
            load_ack <= 1'b0;
            busy     <= 1'b0;
            blank    <= '0;
        end else begin
            state    <= state_n;
            tcnt     <= tcnt_n;
            cks_out  <= cks_n;
            ovf_flag <= ovf_n;
            udf_flag <= udf_n;
            load_ack <= load_ack_n;
            busy     <= busy_n;
            blank    <= blank_n;
        end
    end

    // Next state: load_req beats a clock-select change, which beats counting.
    always_comb begin
        state_n = state;
        cnt_en  = 1'b0;
        case (state)
            S_IDLE: begin
                if (load_req)     state_n = S_LOAD;
                else if (cks_chg) state_n = S_SWITCH;
                else if (tmr_en)  state_n = S_RUN;
            end
            S_LOAD: begin
                if (load_req)     state_n = S_LOAD;
                else if (tmr_en)  state_n = S_RUN;
                else              state_n = S_IDLE;
            end
            S_RUN: begin
                cnt_en = tmr_edge && tmr_en && !load_req;
                if (load_req)     state_n = S_LOAD;
                else if (cks_chg) state_n = S_SWITCH;
                else if (!tmr_en) state_n = S_IDLE;
            end
            S_SWITCH: begin
                if (load_req)          state_n = S_LOAD;
                else if (cks_chg)      state_n = S_SWITCH;
                else if (blank <= BLK_W'(1)) state_n = tmr_en ? S_RUN : S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Datapath: counter, flags, clock-select/blanking and registered status.
    always_comb begin
        tcnt_n  = tcnt;
        cks_n   = cks_out;
        blank_n = '0;
        ovf_set = 1'b0;
        udf_set = 1'b0;

        if (cnt_en) begin
            if (!count_dn) begin
                if (tcnt == {CNT_W{1'b1}}) begin
                    ovf_set = 1'b1;
                    tcnt_n  = wrap_up;
                end else begin
                    tcnt_n = tcnt + CNT_W'(1);
                end
            end else begin
                if (tcnt == '0) begin
                    udf_set = 1'b1;
                    tcnt_n  = wrap_dn;
                end else begin
                    tcnt_n = tcnt - CNT_W'(1);
                end
            end
        end

        if (state_n == S_LOAD) begin
            tcnt_n = tdr;
        end

        // Entry into SWITCH (including a restart from SWITCH) applies the new select and rearms blanking.
        if (state_n == S_SWITCH) begin
            if (state != S_SWITCH || cks_chg) begin
                cks_n   = cks_in;
                blank_n = BLK_W'(BLANK_CYC);
            end else begin
                blank_n = blank - BLK_W'(1);
            end
        end

        ovf_n      = ovf_set | (ovf_flag & ~ovf_clr);
        udf_n      = udf_set | (udf_flag & ~udf_clr);
        load_ack_n = (state_n == S_LOAD);
        busy_n     = (state_n == S_LOAD) || (state_n == S_SWITCH);
    end

endmodule
